// File: rtl/twiddle_gen_pipe.sv
// Pipelined FFT/IFFT twiddle-factor generator built on a quarter-wave cosine ROM.
// Three stages (address, ROM read, sign/output) share one global stall enable.
module twiddle_gen_pipe #(
  parameter int LUT_POINTS = 8192,
  parameter int DATA_WIDTH = 24,
  parameter int TAG_WIDTH  = 8,
  parameter int LOG2_LUT   = $clog2(LUT_POINTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LOG2_LUT-1:0]          in_index,
  input  logic [4:0]                   in_log2n,
  input  logic                         in_inverse,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_real,
  output logic signed [DATA_WIDTH-1:0] out_imag,
  output logic [TAG_WIDTH-1:0]         out_tag,
  output logic                         out_err
);

  localparam int  QTR = LUT_POINTS / 4;
  localparam int  AW  = LOG2_LUT - 1;
  localparam int  RW  = LOG2_LUT - 2;
  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = 2.0 ** (DATA_WIDTH - 1) - 1.0;

  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  logic [4:0]          n_eff;
  logic                clamp_err;
  logic [LOG2_LUT-1:0] k_masked;
  logic [LOG2_LUT-1:0] phase;

  // Clamp log2(N) into range, keep the low n index bits, scale onto the full-circle grid.
  always_comb begin
    n_eff     = in_log2n;
    clamp_err = 1'b0;
    if (in_log2n == 5'd0) begin
      n_eff     = 5'd1;
      clamp_err = 1'b1;
    end else if (in_log2n > 5'(LOG2_LUT)) begin
      n_eff     = 5'(LOG2_LUT);
      clamp_err = 1'b1;
    end
    k_masked = in_index & ~({LOG2_LUT{1'b1}} << n_eff);
    phase    = k_masked << (5'(LOG2_LUT) - n_eff);
  end

  logic                 s1_valid;
  logic                 s1_inverse;
  logic                 s1_err;
  logic [1:0]           s1_quad;
  logic [AW-1:0]        s1_addr_a;
  logic [AW-1:0]        s1_addr_b;
  logic [TAG_WIDTH-1:0] s1_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s1_quad    <= phase[LOG2_LUT-1:LOG2_LUT-2];
      s1_addr_a  <= {1'b0, phase[RW-1:0]};
      s1_addr_b  <= AW'(QTR) - {1'b0, phase[RW-1:0]};
      s1_inverse <= in_inverse;
      s1_err     <= clamp_err;
      s1_tag     <= in_tag;
    end
  end

  // ROM contents are computed at elaboration time: C[i] = round(cos(pi/2*i/Q) * max).
  logic [DATA_WIDTH-1:0] cos_rom [QTR+1];
  for (genvar i = 0; i <= QTR; i++) begin : g_rom
    assign cos_rom[i] = DATA_WIDTH'($rtoi($cos(PI / 2.0 * real'(i) / real'(QTR)) * AMP + 0.5));
  end

  logic                  s2_valid;
  logic                  s2_inverse;
  logic                  s2_err;
  logic [1:0]            s2_quad;
  logic [TAG_WIDTH-1:0]  s2_tag;
  logic [DATA_WIDTH-1:0] rom_a;
  logic [DATA_WIDTH-1:0] rom_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      rom_a      <= cos_rom[s1_addr_a];
      rom_b      <= cos_rom[s1_addr_b];
      s2_quad    <= s1_quad;
      s2_inverse <= s1_inverse;
      s2_err     <= s1_err;
      s2_tag     <= s1_tag;
    end
  end

  logic [DATA_WIDTH-1:0] cos_term;
  logic [DATA_WIDTH-1:0] nsin_term;
  logic [DATA_WIDTH-1:0] imag_term;

  // Quadrant folding: a = C[r], b = C[Q-r]; nsin_term is -sin before the inverse flag.
  always_comb begin
    cos_term  = rom_a;
    nsin_term = -rom_b;
    case (s2_quad)
      2'd0: begin cos_term = rom_a;  nsin_term = -rom_b; end
      2'd1: begin cos_term = -rom_b; nsin_term = -rom_a; end
      2'd2: begin cos_term = -rom_a; nsin_term = rom_b;  end
      2'd3: begin cos_term = rom_b;  nsin_term = rom_a;  end
    endcase
    imag_term = s2_inverse ? -nsin_term : nsin_term;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_real <= cos_term;
        out_imag <= imag_term;
        out_tag  <= s2_tag;
        out_err  <= s2_err;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_gen_pipe.sv
// Scoreboard bench for twiddle_gen_pipe: a real-arithmetic model predicts each result,
// a negedge monitor pops and compares whenever the DUT hands a result over.
module tb_twiddle_gen_pipe;

  localparam int  LOG2 = 13;
  localparam int  DW   = 24;
  localparam int  TW   = 8;
  localparam real PI   = 3.14159265358979323846;
  localparam real AMP  = 2.0 ** (DW - 1) - 1.0;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [LOG2-1:0]      in_index;
  logic [4:0]           in_log2n;
  logic                 in_inverse;
  logic [TW-1:0]        in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_real;
  logic signed [DW-1:0] out_imag;
  logic [TW-1:0]        out_tag;
  logic                 out_err;

  twiddle_gen_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_index   (in_index),
    .in_log2n   (in_log2n),
    .in_inverse (in_inverse),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_real   (out_real),
    .out_imag   (out_imag),
    .out_tag    (out_tag),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          err;
    int            acc;
    bit            lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   stall_left = 0;
  bit   rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // W = exp(-/+ j*2*pi*k/N), evaluated directly with trig on the requested angle.
  function automatic exp_t model(input logic [LOG2-1:0] idx, input logic [4:0] l2n,
                                 input logic inv, input logic [TW-1:0] tag);
    exp_t e;
    int   n, npts, k, re, im;
    real  th;
    n = int'(l2n);
    e.err = 1'b0;
    if (n < 1) begin
      n = 1;
      e.err = 1'b1;
    end else if (n > LOG2) begin
      n = LOG2;
      e.err = 1'b1;
    end
    npts = 1 << n;
    k    = int'(idx) % npts;
    th   = 2.0 * PI * real'(k) / real'(npts);
    re   = rnd($cos(th) * AMP);
    im   = rnd(-$sin(th) * AMP);
    if (inv) im = -im;
    e.re  = DW'(re);
    e.im  = DW'(im);
    e.tag = tag;
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic [LOG2-1:0] idx, input logic [4:0] l2n,
                                input logic inv, input logic [TW-1:0] tag, input bit lat);
    exp_t e;
    int   guard;
    in_valid   = 1'b1;
    in_index   = idx;
    in_log2n   = l2n;
    in_inverse = inv;
    in_tag     = tag;
    guard      = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      guard++;
      @(posedge clk);
      #2;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0 for tag 0x%0h", tag);
    end else begin
      e     = model(idx, l2n, inv, tag);
      e.acc = cyc;
      e.lat = lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      guard++;
      idle();
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Output-side backpressure: forced stall cycles first, then random or always-ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  bit            prev_stall = 0;
  bit            prev_rst = 0;
  logic [DW-1:0] prev_real, prev_imag;
  logic [TW-1:0] prev_tag;
  logic          prev_err;

  // Monitor: stability while stalled, in_ready during stall, scoreboard pop on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (prev_stall && !prev_rst) begin
      check_output("stall_valid", 32'(out_valid), 32'd1);
      check_output("stall_real", 32'($unsigned(out_real)), 32'(prev_real));
      check_output("stall_imag", 32'($unsigned(out_imag)), 32'(prev_imag));
      check_output("stall_tag", 32'(out_tag), 32'(prev_tag));
      check_output("stall_err", 32'(out_err), 32'(prev_err));
    end
    if (out_valid && !out_ready && !rst) begin
      check_output("stall_in_ready", 32'(in_ready), 32'd0);
    end
    if (out_valid && out_ready && !rst) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected_output: tag 0x%0h with empty scoreboard", out_tag);
      end else begin
        e = exp_q.pop_front();
        check_output("tag", 32'(out_tag), 32'(e.tag));
        check_output("real", 32'($unsigned(out_real)), 32'(e.re));
        check_output("imag", 32'($unsigned(out_imag)), 32'(e.im));
        check_output("err", 32'(out_err), 32'(e.err));
        if (e.lat) check_output("latency", 32'(cyc), 32'(e.acc + 3));
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_rst   = rst;
    prev_real  = $unsigned(out_real);
    prev_imag  = $unsigned(out_imag);
    prev_tag   = out_tag;
    prev_err   = out_err;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sweep_n[3] = '{3, 6, 13};
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_index   = '0;
    in_log2n   = 5'd10;
    in_inverse = 1'b0;
    in_tag     = '0;
    repeat (2) @(posedge clk);
    #2;
    @(negedge clk);
    check_output("rst_valid", 32'(out_valid), 32'd0);
    check_output("rst_real", 32'($unsigned(out_real)), 32'd0);
    check_output("rst_imag", 32'($unsigned(out_imag)), 32'd0);
    check_output("rst_tag", 32'(out_tag), 32'd0);
    check_output("rst_err", 32'(out_err), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle();

    // Directed points: k=0, quarter and half turn, inverse direction.
    apply_stimulus(13'd0, 5'd10, 1'b0, 8'h01, 1'b1);
    wait_drain();
    apply_stimulus(13'd256, 5'd10, 1'b0, 8'h02, 1'b1);
    apply_stimulus(13'd512, 5'd10, 1'b0, 8'h03, 1'b1);
    wait_drain();
    apply_stimulus(13'd256, 5'd10, 1'b1, 8'h04, 1'b1);
    wait_drain();

    foreach (sweep_n[s]) begin
      for (int k = 0; k < (1 << sweep_n[s]); k++) begin
        apply_stimulus(LOG2'(k), 5'(sweep_n[s]), 1'($urandom_range(0, 1)), TW'(k), 1'b0);
      end
    end
    wait_drain();

    // Stream of 16 with a 5-cycle output stall in the middle.
    for (int k = 0; k < 16; k++) begin
      if (k == 8) stall_left = 5;
      apply_stimulus(LOG2'(k), 5'd4, 1'b0, TW'(k), 1'b0);
    end
    wait_drain();

    // Clamping and ignored upper index bits.
    apply_stimulus(LOG2'($urandom), 5'd0, 1'b0, 8'h50, 1'b0);
    apply_stimulus(LOG2'($urandom), 5'd20, 1'b1, 8'h51, 1'b0);
    apply_stimulus(LOG2'($urandom), 5'd31, 1'b0, 8'h52, 1'b0);
    apply_stimulus(13'd1029, 5'd10, 1'b0, 8'h53, 1'b0);
    apply_stimulus(13'd5, 5'd10, 1'b0, 8'h54, 1'b0);
    wait_drain();

    // Reset with three requests in flight, then a fresh request.
    apply_stimulus(13'd100, 5'd10, 1'b0, 8'hA0, 1'b0);
    apply_stimulus(13'd200, 5'd10, 1'b0, 8'hA1, 1'b0);
    stall_left = 1;
    apply_stimulus(13'd300, 5'd10, 1'b0, 8'hA2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_output("post_rst_valid", 32'(out_valid), 32'd0);
    check_output("post_rst_real", 32'($unsigned(out_real)), 32'd0);
    check_output("post_rst_imag", 32'($unsigned(out_imag)), 32'd0);
    check_output("post_rst_tag", 32'(out_tag), 32'd0);
    check_output("post_rst_err", 32'(out_err), 32'd0);
    @(posedge clk);
    #2;
    apply_stimulus(13'd384, 5'd10, 1'b1, 8'hA3, 1'b1);
    wait_drain();

    // Random traffic with random backpressure and gaps.
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [4:0] l2n;
      l2n = (i % 8 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, LOG2));
      apply_stimulus(LOG2'($urandom), l2n, 1'($urandom_range(0, 1)), TW'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) idle();
    end
    wait_drain();
    rand_ready = 1'b0;
    repeat (4) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
